inst_fetcher: RTL and testbench
===============================

INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter ICACHE_IDX_W, 4, index width; the cache holds 2**ICACHE_IDX_W direct-mapped one-word lines.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-low.
REQ-004 rdy_in  input  1  global enable; when low, all state and outputs hold.
REQ-005 if_to_mc_PC  output  32  word address of the cache-miss fill request.
REQ-006 if_to_mc_ready  output  1  fill request valid; held until mc_to_if_ready is sampled.
REQ-007 mc_to_if_ready  input  1  fill data valid.
REQ-008 mc_to_if_inst  input  32  fill instruction word, little-endian assembled.
REQ-009 dec_ready  input  1  decoder accepts the output slot at this edge.
REQ-010 if_to_dec_valid  output  1  output slot holds an instruction.
REQ-011 if_to_dec_inst  output  32  instruction.
REQ-012 if_to_dec_PC  output  32  PC of if_to_dec_inst.
REQ-013 rob_flush  input  1  redirect request, e.g. mispredict or exception.
REQ-014 rob_new_PC  input  32  redirect target, word aligned.

Function
REQ-015 Each cache line SHALL store valid, tag = PC[31:ICACHE_IDX_W+2], and data.
REQ-016 Index SHALL be PC[ICACHE_IDX_W+1:2]; PC[1:0] is always 00.
REQ-017 FSM states SHALL be RUN and WAIT_MEM.
REQ-018 Slot free SHALL mean !if_to_dec_valid || dec_ready.
REQ-019 RUN, slot free, hit: next edge sets valid=1, inst=line data, PC_out=PC, and PC<=PC+4; throughput is 1 instr/cycle and hit latency is 1 cycle.
REQ-020 RUN, slot free, miss: next edge sets if_to_mc_ready=1, latches fill address = PC into if_to_mc_PC, enters WAIT_MEM, and clears valid if dec_ready consumed the slot.
REQ-021 RUN, slot not free: no lookup, PC holds, and outputs hold.
REQ-022 WAIT_MEM: request and address SHALL stay stable.
REQ-023 WAIT_MEM, on the edge sampling mc_to_if_ready=1: write the line at the fill address (valid=1, tag, data), drop if_to_mc_ready that same edge, and return to RUN.
REQ-024 After a fill, the next RUN lookup hits, so miss-to-output is fill latency + 2 cycles.
REQ-025 mc_to_if_ready sampled outside WAIT_MEM SHALL be ignored, because the controller may hold ready an extra cycle.
REQ-026 PC wraps modulo 2**32; 0xFFFFFFFC + 4 = 0.
REQ-027 rob_flush has priority over all other events: next edge sets PC<=rob_new_PC and valid<=0; dec_ready is ignored that cycle.
REQ-028 rob_flush in WAIT_MEM: the state stays WAIT_MEM until fill completes, and the fill SHALL still be written using the latched fill address.
REQ-029 The redirected PC is not fetched until RUN.
REQ-030 Simultaneous flush and mc_to_if_ready in WAIT_MEM: write the line, return to RUN, and take the new PC.
REQ-031 Simultaneous hit output and dec_ready: back-to-back replacement, with no bubble.
REQ-032 No cache invalidation other than reset; self-modifying code is unsupported.

Reset
REQ-033 On an edge with rst_in=0: PC=0, state=RUN, all line valid bits=0, if_to_mc_ready=0, if_to_mc_PC=0, if_to_dec_valid=0, if_to_dec_inst=0, if_to_dec_PC=0.
REQ-034 Reset mid-WAIT_MEM SHALL abandon the request; the controller is reset by the same signal.
REQ-035 Reset SHALL take priority over rdy_in.

Structure
REQ-036 ADDR_TYPE[31:0], DATA_TYPE[31:0], TRUE/FALSE, and ICACHE_IDX_W default SHALL live in the shared defines header.
REQ-037 The cache array SHALL be a sub-module icache with a combinational hit/data read port and one synchronous write port.
REQ-038 FSM, PC, and output slot SHALL stay in inst_fetcher.

Verification
REQ-039 Reset, then memory word 0 = 0x00000013 with 3-cycle fill: request PC 0x0, then output inst 0x00000013 / PC 0x0, then next request 0x4.
REQ-040 Loop 0x0..0xC preloaded, dec_ready=1 constant: four outputs on consecutive cycles with PCs 0x0, 0x4, 0x8, 0xC, and no if_to_mc_ready.
REQ-041 dec_ready=0 for 5 cycles while valid: inst and PC stable, PC not advanced, and one output on the first dec_ready=1.
REQ-042 Flush to 0x100 during WAIT_MEM for 0x40: line 0x40 written, no output for 0x40, next request 0x100.
REQ-043 Alias test, 0x0 and 0x40 (ICACHE_IDX_W=4): fetch 0x0 then 0x40, then refetch 0x0 raises a miss.
REQ-044 rdy_in=0 for 4 cycles mid-WAIT_MEM with mc_to_if_ready pulsing: no state change, and completion only after rdy_in returns.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its cache.
// Address/data words are 32 bits; PCs are always word aligned.
package inst_fetcher_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int ICACHE_IDX_W_DEF = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [ADDR_W-1:0] addr_type_t;
    typedef logic [DATA_W-1:0] data_type_t;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } fetch_state_e;

    // Sequential PC step; wraps naturally at 2**32.
    function automatic addr_type_t pc_next(input addr_type_t pc);
        return pc + addr_type_t'(4);
    endfunction

endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache, one word per line: combinational lookup, one sync write port.
// Latency: read 0 cycles, write visible next cycle; no backpressure (always accepts a write).
// Only the valid bits are reset, so stale tag/data can never produce a hit.
module inst_fetcher_icache
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_W-3:0]     rd_waddr_i,
    output logic                  hit_o,
    output data_type_t            rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-3:0]     wr_waddr_i,
    input  data_type_t            wr_data_i
);

    localparam int NLINES = 2 ** IDX_W;
    localparam int TAG_W  = ADDR_W - 2 - IDX_W;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    data_type_t        data_q [NLINES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_waddr_i[IDX_W-1:0];
    assign rd_tag = rd_waddr_i[ADDR_W-3:IDX_W];
    assign wr_idx = wr_waddr_i[IDX_W-1:0];
    assign wr_tag = wr_waddr_i[ADDR_W-3:IDX_W];

    assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data_o = data_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= TRUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data_i;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: icache lookup per PC, miss fill via memory controller, one-entry decoder slot.
// Latency: hit 1 cycle, miss fill latency + 2; rdy_in low freezes everything, a full slot without dec_ready stalls fetch.
// Redirects (rob_flush) win over everything except reset; an in-flight fill always completes to its latched address.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    output addr_type_t if_to_mc_PC,
    output logic       if_to_mc_ready,
    input  logic       mc_to_if_ready,
    input  data_type_t mc_to_if_inst,
    input  logic       dec_ready,
    output logic       if_to_dec_valid,
    output data_type_t if_to_dec_inst,
    output addr_type_t if_to_dec_PC,
    input  logic       rob_flush,
    input  addr_type_t rob_new_PC
);

    fetch_state_e state_q, state_d;
    addr_type_t   pc_q, pc_d;
    logic         mc_req_q, mc_req_d;
    addr_type_t   mc_pc_q, mc_pc_d;
    logic         dec_vld_q, dec_vld_d;
    data_type_t   dec_inst_q, dec_inst_d;
    addr_type_t   dec_pc_q, dec_pc_d;

    logic       cache_hit;
    data_type_t cache_data;
    logic       fill_we;
    logic       slot_free;

    inst_fetcher_icache #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk_i      (clk_in),
        .rst_n_i    (rst_in),
        .rd_waddr_i (pc_q[ADDR_W-1:2]),
        .hit_o      (cache_hit),
        .rd_data_o  (cache_data),
        .wr_en_i    (fill_we),
        .wr_waddr_i (mc_pc_q[ADDR_W-1:2]),
        .wr_data_i  (mc_to_if_inst)
    );

    assign slot_free = !dec_vld_q || dec_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mc_req_d   = mc_req_q;
        mc_pc_d    = mc_pc_q;
        dec_vld_d  = dec_vld_q;
        dec_inst_d = dec_inst_q;
        dec_pc_d   = dec_pc_q;
        fill_we    = FALSE;

        if (rdy_in) begin
            case (state_q)
                RUN: begin
                    if (rob_flush) begin
                        pc_d      = rob_new_PC;
                        dec_vld_d = FALSE;
                    end else if (slot_free) begin
                        if (cache_hit) begin
                            dec_vld_d  = TRUE;
                            dec_inst_d = cache_data;
                            dec_pc_d   = pc_q;
                            pc_d       = pc_next(pc_q);
                        end else begin
                            mc_req_d  = TRUE;
                            mc_pc_d   = pc_q;
                            state_d   = WAIT_MEM;
                            dec_vld_d = FALSE;
                        end
                    end
                end
                WAIT_MEM: begin
                    // The slot was emptied on entry; keep consume semantics anyway.
                    if (dec_ready) begin
                        dec_vld_d = FALSE;
                    end
                    if (rob_flush) begin
                        pc_d      = rob_new_PC;
                        dec_vld_d = FALSE;
                    end
                    if (mc_to_if_ready) begin
                        fill_we  = TRUE;
                        mc_req_d = FALSE;
                        state_d  = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= RUN;
            pc_q       <= '0;
            mc_req_q   <= FALSE;
            mc_pc_q    <= '0;
            dec_vld_q  <= FALSE;
            dec_inst_q <= '0;
            dec_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mc_req_q   <= mc_req_d;
            mc_pc_q    <= mc_pc_d;
            dec_vld_q  <= dec_vld_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q   <= dec_pc_d;
        end
    end

    assign if_to_mc_PC     = mc_pc_q;
    assign if_to_mc_ready  = mc_req_q;
    assign if_to_dec_valid = dec_vld_q;
    assign if_to_dec_inst  = dec_inst_q;
    assign if_to_dec_PC    = dec_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: the bench plays memory controller, decoder and ROB.
module tb_inst_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] if_to_mc_PC;
    logic        if_to_mc_ready;
    logic        mc_to_if_ready;
    logic [31:0] mc_to_if_inst;
    logic        dec_ready;
    logic        if_to_dec_valid;
    logic [31:0] if_to_dec_inst;
    logic [31:0] if_to_dec_PC;
    logic        rob_flush;
    logic [31:0] rob_new_PC;

    int compared   = 0;
    int mismatched = 0;

    inst_fetcher #(.ICACHE_IDX_W(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .if_to_mc_PC     (if_to_mc_PC),
        .if_to_mc_ready  (if_to_mc_ready),
        .mc_to_if_ready  (mc_to_if_ready),
        .mc_to_if_inst   (mc_to_if_inst),
        .dec_ready       (dec_ready),
        .if_to_dec_valid (if_to_dec_valid),
        .if_to_dec_inst  (if_to_dec_inst),
        .if_to_dec_PC    (if_to_dec_PC),
        .rob_flush       (rob_flush),
        .rob_new_PC      (rob_new_PC)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b0; mc_to_if_ready = 1'b0; mc_to_if_inst = '0;
        dec_ready = 1'b0; rob_flush = 1'b0; rob_new_PC = '0;
        step(); step();
        compared++; if (if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL reset_mc_ready got %b want 0", if_to_mc_ready); end
        compared++; if (if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL reset_mc_PC got %h want 0", if_to_mc_PC); end
        compared++; if (if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", if_to_dec_valid); end
        compared++; if (if_to_dec_inst !== 32'h0) begin mismatched++; $display("FAIL reset_inst got %h want 0", if_to_dec_inst); end
        compared++; if (if_to_dec_PC !== 32'h0) begin mismatched++; $display("FAIL reset_PC got %h want 0", if_to_dec_PC); end
        rdy_in = 1'b1;
    endtask

    task automatic test_first_fetch();
        rst_in = 1'b1;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL first_req got %b/%h want 1/00000000", if_to_mc_ready, if_to_mc_PC); end
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL first_req_hold got %b/%h want 1/00000000", if_to_mc_ready, if_to_mc_PC); end
        step();
        mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00000013;
        step();
        compared++; if (if_to_mc_ready !== 1'b0 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL first_fill_drop got req=%b vld=%b want 0/0", if_to_mc_ready, if_to_dec_valid); end
        // ready held one extra cycle while back in RUN must be ignored
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_inst !== 32'h00000013 || if_to_dec_PC !== 32'h0) begin mismatched++; $display("FAIL first_out got %b/%h/%h want 1/00000013/00000000", if_to_dec_valid, if_to_dec_inst, if_to_dec_PC); end
        compared++; if (if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL first_extra_ready got %b want 0", if_to_mc_ready); end
        mc_to_if_ready = 1'b0; dec_ready = 1'b1;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h4 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL second_req got %b/%h vld=%b want 1/00000004 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
    endtask

    task automatic test_preload();
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        addrs = '{32'h4, 32'h8, 32'hC};
        words = '{32'h00000413, 32'h00000813, 32'h00000C13};
        for (int i = 0; i < 3; i++) begin
            mc_to_if_ready = 1'b1; mc_to_if_inst = words[i];
            step();
            mc_to_if_ready = 1'b0;
            step();
            compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== addrs[i] || if_to_dec_inst !== words[i]) begin mismatched++; $display("FAIL preload_out[%0d] got %b/%h/%h want 1/%h/%h", i, if_to_dec_valid, if_to_dec_PC, if_to_dec_inst, addrs[i], words[i]); end
            step();
            compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== addrs[i] + 32'h4) begin mismatched++; $display("FAIL preload_req[%0d] got %b/%h want 1/%h", i, if_to_mc_ready, if_to_mc_PC, addrs[i] + 32'h4); end
        end
    endtask

    task automatic test_flush_in_wait();
        rob_flush = 1'b1; rob_new_PC = 32'h0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h10 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL flushwait_hold got %b/%h vld=%b want 1/00000010 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
        rob_flush = 1'b0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00001013;
        step();
        compared++; if (if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL flushwait_fill got %b want 0", if_to_mc_ready); end
        mc_to_if_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs   [4];
        logic [31:0] insts [4];
        pcs   = '{32'h0, 32'h4, 32'h8, 32'hC};
        insts = '{32'h00000013, 32'h00000413, 32'h00000813, 32'h00000C13};
        for (int i = 0; i < 4; i++) begin
            step();
            compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== pcs[i] || if_to_dec_inst !== insts[i] || if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL b2b[%0d] got %b/%h/%h req=%b want 1/%h/%h req=0", i, if_to_dec_valid, if_to_dec_PC, if_to_dec_inst, if_to_mc_ready, pcs[i], insts[i]); end
        end
    endtask

    task automatic test_stall();
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'hC || if_to_dec_inst !== 32'h00000C13 || if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL stall[%0d] got %b/%h/%h req=%b want 1/0000000c/00000c13 req=0", i, if_to_dec_valid, if_to_dec_PC, if_to_dec_inst, if_to_mc_ready); end
        end
        dec_ready = 1'b1;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'h10 || if_to_dec_inst !== 32'h00001013) begin mismatched++; $display("FAIL stall_release got %b/%h/%h want 1/00000010/00001013", if_to_dec_valid, if_to_dec_PC, if_to_dec_inst); end
        dec_ready = 1'b0;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'h10) begin mismatched++; $display("FAIL stall_single got %b/%h want 1/00000010", if_to_dec_valid, if_to_dec_PC); end
        dec_ready = 1'b1;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h14 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL stall_next_req got %b/%h vld=%b want 1/00000014 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
    endtask

    task automatic test_flush_to_0x100();
        rob_flush = 1'b1; rob_new_PC = 32'h40;
        step();
        rob_flush = 1'b0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00001413;
        step();
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h40) begin mismatched++; $display("FAIL req_0x40 got %b/%h want 1/00000040", if_to_mc_ready, if_to_mc_PC); end
        rob_flush = 1'b1; rob_new_PC = 32'h100;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h40 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL flush100_hold got %b/%h vld=%b want 1/00000040 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
        rob_flush = 1'b0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00004013;
        step();
        compared++; if (if_to_mc_ready !== 1'b0 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL flush100_fill got req=%b vld=%b want 0/0", if_to_mc_ready, if_to_dec_valid); end
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h100 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL flush100_req got %b/%h vld=%b want 1/00000100 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
        mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00010013;
        step();
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'h100 || if_to_dec_inst !== 32'h00010013) begin mismatched++; $display("FAIL flush100_out got %b/%h/%h want 1/00000100/00010013", if_to_dec_valid, if_to_dec_PC, if_to_dec_inst); end
    endtask

    task automatic test_alias();
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h104) begin mismatched++; $display("FAIL alias_req104 got %b/%h want 1/00000104", if_to_mc_ready, if_to_mc_PC); end
        // flush and fill completion on the same edge
        rob_flush = 1'b1; rob_new_PC = 32'h0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00010413;
        step();
        compared++; if (if_to_mc_ready !== 1'b0 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL simul_flush_fill got req=%b vld=%b want 0/0", if_to_mc_ready, if_to_dec_valid); end
        rob_flush = 1'b0; mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL alias_miss got %b/%h want 1/00000000", if_to_mc_ready, if_to_mc_PC); end
        mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00000013;
        step();
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'h0 || if_to_dec_inst !== 32'h00000013) begin mismatched++; $display("FAIL alias_out got %b/%h/%h want 1/00000000/00000013", if_to_dec_valid, if_to_dec_PC, if_to_dec_inst); end
    endtask

    task automatic test_rdy_stall();
        rob_flush = 1'b1; rob_new_PC = 32'h200;
        step();
        compared++; if (if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL rdy_flush got %b want 0", if_to_dec_valid); end
        rob_flush = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h200) begin mismatched++; $display("FAIL rdy_req got %b/%h want 1/00000200", if_to_mc_ready, if_to_mc_PC); end
        rdy_in = 1'b0; mc_to_if_inst = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            mc_to_if_ready = (i % 2 == 0);
            step();
            compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h200 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL rdy_hold[%0d] got %b/%h vld=%b want 1/00000200 vld=0", i, if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
        end
        rdy_in = 1'b1; mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1) begin mismatched++; $display("FAIL rdy_resume got %b want 1", if_to_mc_ready); end
        mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00020013;
        step();
        compared++; if (if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL rdy_fill got %b want 0", if_to_mc_ready); end
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'h200 || if_to_dec_inst !== 32'h00020013) begin mismatched++; $display("FAIL rdy_out got %b/%h/%h want 1/00000200/00020013", if_to_dec_valid, if_to_dec_PC, if_to_dec_inst); end
    endtask

    task automatic test_wrap();
        rob_flush = 1'b1; rob_new_PC = 32'hFFFFFFFC;
        step();
        compared++; if (if_to_dec_valid !== 1'b0 || if_to_mc_ready !== 1'b0) begin mismatched++; $display("FAIL wrap_flush got vld=%b req=%b want 0/0", if_to_dec_valid, if_to_mc_ready); end
        rob_flush = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'hFFFFFFFC) begin mismatched++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", if_to_mc_ready, if_to_mc_PC); end
        mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h000000AB;
        step();
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_dec_valid !== 1'b1 || if_to_dec_PC !== 32'hFFFFFFFC || if_to_dec_inst !== 32'h000000AB) begin mismatched++; $display("FAIL wrap_out got %b/%h/%h want 1/fffffffc/000000ab", if_to_dec_valid, if_to_dec_PC, if_to_dec_inst); end
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL wrap_next got %b/%h want 1/00000000", if_to_mc_ready, if_to_mc_PC); end
    endtask

    task automatic test_reset_mid_wait();
        rst_in = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b0 || if_to_mc_PC !== 32'h0 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL midreset got %b/%h vld=%b want 0/00000000 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
        rst_in = 1'b1;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h0) begin mismatched++; $display("FAIL midreset_req got %b/%h want 1/00000000", if_to_mc_ready, if_to_mc_PC); end
        rob_flush = 1'b1; rob_new_PC = 32'h104;
        step();
        rob_flush = 1'b0; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00000013;
        step();
        mc_to_if_ready = 1'b0;
        step();
        compared++; if (if_to_mc_ready !== 1'b1 || if_to_mc_PC !== 32'h104 || if_to_dec_valid !== 1'b0) begin mismatched++; $display("FAIL midreset_invalidated got %b/%h vld=%b want 1/00000104 vld=0", if_to_mc_ready, if_to_mc_PC, if_to_dec_valid); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_preload();
        test_flush_in_wait();
        test_back_to_back();
        test_stall();
        test_flush_to_0x100();
        test_alias();
        test_rdy_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, compared=%0d", compared);
        $fatal(1);
    end

endmodule
